// File: rtl/spmv_issue_ctrl.sv
// rtl/spmv_issue_ctrl.sv - CSR SpMV issue sequencer with same-row read-after-write hazard stalls
// Optional feature macro: SPMV_STALL_CNT_EN adds the o_stall_cnt hazard-bubble counter.
module spmv_issue_ctrl #(
  parameter int N_ROWS   = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [7:0]              i_nnz,
  input  logic [8*(N_ROWS+1)-1:0] i_row_ptr,
  output logic                    o_rd_en,
  output logic [7:0]              o_rd_addr,
  output logic                    o_wr_en,
  output logic [7:0]              o_count,
  output logic                    o_busy,
  output logic                    o_done
`ifdef SPMV_STALL_CNT_EN
  ,
  output logic [15:0]             o_stall_cnt
`endif
);

  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [7:0]                      idx_q, idx_d;
  logic [7:0]                      nnz_q, nnz_d;
  logic [8*(N_ROWS+1)-1:0]         row_ptr_q, row_ptr_d;

  // In-flight pipe: entry 0 is the newest issue, entry PIPE_LAT-1 is write-back.
  logic [PIPE_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [PIPE_LAT-1:0]             pipe_rv_q, pipe_rv_d;
  logic [PIPE_LAT-1:0][ROW_W-1:0]  pipe_row_q, pipe_row_d;
  logic [PIPE_LAT-1:0][7:0]        pipe_cnt_q, pipe_cnt_d;

`ifdef SPMV_STALL_CNT_EN
  logic [15:0]                     stall_cnt_q, stall_cnt_d;
`endif

  logic [8:0]                      idx_p1;
  logic                            cand_rv;
  logic [ROW_W-1:0]                cand_row;
  logic                            hazard;
  logic                            issue;
  logic                            last_issue;
  logic                            drain_empty;

  assign idx_p1 = {1'b0, idx_q} + 9'd1;

  // First row whose pointer window (row_ptr[k], row_ptr[k+1]] holds idx+1.
  always_comb begin
    cand_rv  = 1'b0;
    cand_row = '0;
    for (int k = 0; k < N_ROWS; k++) begin
      if (!cand_rv &&
          ({1'b0, row_ptr_q[8*k +: 8]} < idx_p1) &&
          (idx_p1 <= {1'b0, row_ptr_q[8*(k+1) +: 8]})) begin
        cand_rv  = 1'b1;
        cand_row = ROW_W'(k);
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (pipe_vld_q[i] && pipe_rv_q[i] && cand_rv && (pipe_row_q[i] == cand_row)) begin
        hazard = 1'b1;
      end
    end
  end

  // The exit entry leaves this cycle, so only the younger entries gate DONE.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      if (pipe_vld_q[i]) begin
        drain_empty = 1'b0;
      end
    end
  end

  assign issue      = (state_q == S_ISSUE) && !hazard;
  assign last_issue = issue && (idx_q == (nnz_q - 8'd1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nnz_d     = nnz_q;
    row_ptr_d = row_ptr_q;
`ifdef SPMV_STALL_CNT_EN
    stall_cnt_d = stall_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          nnz_d     = i_nnz;
          row_ptr_d = i_row_ptr;
          idx_d     = 8'd0;
          state_d   = (i_nnz != 8'd0) ? S_ISSUE : S_DONE;
`ifdef SPMV_STALL_CNT_EN
          stall_cnt_d = 16'd0;
`endif
        end
      end
      S_ISSUE: begin
        if (issue) begin
          idx_d = idx_q + 8'd1;
          if (last_issue) begin
            state_d = S_DRAIN;
          end
        end
`ifdef SPMV_STALL_CNT_EN
        if (hazard && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
`endif
      end
      S_DRAIN: begin
        if (drain_empty) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_rv_d     = '0;
    pipe_row_d    = '0;
    pipe_cnt_d    = '0;
    pipe_vld_d[0] = issue;
    pipe_rv_d[0]  = issue && cand_rv;
    pipe_row_d[0] = issue ? cand_row : '0;
    pipe_cnt_d[0] = issue ? idx_p1[7:0] : 8'd0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_rv_d[i]  = pipe_rv_q[i-1];
      pipe_row_d[i] = pipe_row_q[i-1];
      pipe_cnt_d[i] = pipe_cnt_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      nnz_q      <= 8'd0;
      row_ptr_q  <= '0;
      pipe_vld_q <= '0;
      pipe_rv_q  <= '0;
      pipe_row_q <= '0;
      pipe_cnt_q <= '0;
`ifdef SPMV_STALL_CNT_EN
      stall_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nnz_q      <= nnz_d;
      row_ptr_q  <= row_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_rv_q  <= pipe_rv_d;
      pipe_row_q <= pipe_row_d;
      pipe_cnt_q <= pipe_cnt_d;
`ifdef SPMV_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign o_rd_en   = issue;
  assign o_rd_addr = issue ? idx_q : 8'd0;
  assign o_wr_en   = pipe_vld_q[PIPE_LAT-1];
  assign o_count   = pipe_cnt_q[PIPE_LAT-1];
  assign o_busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign o_done    = (state_q == S_DONE);
`ifdef SPMV_STALL_CNT_EN
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
